// File: rtl/ap_fifo_share_pkg.sv
// Shared types and defaults for the ap_fifo channel-sharing arbiter.
package ap_fifo_share_pkg;
  localparam int NCH_DEF       = 4;
  localparam int DW_DEF        = 128;
  localparam int TAG_DEPTH_DEF = 32;

  typedef logic [$clog2(NCH_DEF)-1:0] chan_t;

  typedef enum logic {ARB = 1'b0, BURST = 1'b1} state_t;
endpackage

// File: rtl/ap_fifo_share_arbiter_tag_fifo.sv
// In-order FIFO of source-channel tags for words in flight inside the IP.
module tag_fifo
  import ap_fifo_share_pkg::*;
#(
  parameter int W     = $bits(chan_t),
  parameter int DEPTH = TAG_DEPTH_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   cnt_q;

  always_ff @(posedge clk)
    if (push) mem_q[wptr_q] <= din;

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end

  assign head  = mem_q[rptr_q];
  assign full  = (cnt_q == (AW+1)'(DEPTH));
  assign empty = (cnt_q == '0);
endmodule

// File: rtl/ap_fifo_share_arbiter.sv
// Shares one ap_fifo IP among NCH channel pairs: round-robin bursts in, tag-steered out.
// Optional ARB_STATS_EN adds per-channel delivered-word counters on stat_words.
module ap_fifo_share_arbiter
  import ap_fifo_share_pkg::*;
#(
  parameter int NCH       = NCH_DEF,
  parameter int DW        = DW_DEF,
  parameter int BURST_LEN = 16,
  parameter int TAG_DEPTH = TAG_DEPTH_DEF
) (
  input  logic                   ap_clk,
  input  logic                   ap_rst,
  input  logic [NCH*DW-1:0]      in_r_dout,
  input  logic [NCH-1:0]         in_r_empty_n,
  output logic [NCH-1:0]         in_r_read,
  output logic [NCH*DW-1:0]      out_r_din,
  input  logic [NCH-1:0]         out_r_full,
  output logic [NCH-1:0]         out_r_write,
  output logic [DW-1:0]          ip_in_dout,
  output logic                   ip_in_empty_n,
  input  logic                   ip_in_read,
  input  logic [DW-1:0]          ip_out_din,
  output logic                   ip_out_full_n,
  input  logic                   ip_out_write,
  output logic [$clog2(NCH)-1:0] grant,
  output logic                   busy
`ifdef ARB_STATS_EN
  ,
  output logic [NCH*32-1:0]      stat_words
`endif
);
  localparam int CW   = $clog2(NCH);
  localparam int CNTW = $clog2(BURST_LEN + 1);

  state_t          state_q;
  logic [CW-1:0]   grant_q, last_q, pick, tag_head;
  logic [CNTW-1:0] cnt_q;
  logic            tag_full, tag_empty, xfer_in, xfer_out;

  // Rotating priority: the channel right after last wins, last itself ranks lowest.
  always_comb begin
    pick = '0;
    for (int i = NCH; i >= 1; i--)
      if (in_r_empty_n[last_q + CW'(i)]) pick = last_q + CW'(i);
  end

  assign ip_in_dout    = in_r_dout[grant_q*DW +: DW];
  assign ip_in_empty_n = (state_q == BURST) && in_r_empty_n[grant_q] && !tag_full;
  assign xfer_in       = ip_in_read && ip_in_empty_n;

  assign ip_out_full_n = !tag_empty && !out_r_full[tag_head];
  assign xfer_out      = ip_out_write && ip_out_full_n;
  assign out_r_din     = {NCH{ip_out_din}};

  always_comb begin
    in_r_read            = '0;
    in_r_read[grant_q]   = xfer_in;
    out_r_write          = '0;
    out_r_write[tag_head] = xfer_out;
  end

  always_ff @(posedge ap_clk or posedge ap_rst)
    if (ap_rst) begin
      state_q <= ARB;
      grant_q <= '0;
      last_q  <= CW'(NCH-1);
      cnt_q   <= '0;
    end else begin
      case (state_q)
        ARB:
          if (|in_r_empty_n) begin
            grant_q <= pick;
            last_q  <= pick;
            cnt_q   <= '0;
            state_q <= BURST;
          end
        BURST: begin
          if (xfer_in) cnt_q <= cnt_q + 1'b1;
          if ((xfer_in && cnt_q == CNTW'(BURST_LEN-1)) ||
              (!in_r_empty_n[grant_q] && !xfer_in))
            state_q <= ARB;
        end
        default: state_q <= ARB;
      endcase
    end

  assign grant = grant_q;
  assign busy  = (state_q == BURST);

  tag_fifo #(.W(CW), .DEPTH(TAG_DEPTH)) u_tags (
    .clk   (ap_clk),
    .rst   (ap_rst),
    .push  (xfer_in),
    .pop   (xfer_out),
    .din   (grant_q),
    .head  (tag_head),
    .full  (tag_full),
    .empty (tag_empty)
  );

`ifdef ARB_STATS_EN
  logic [NCH-1:0][31:0] stat_q;

  always_ff @(posedge ap_clk or posedge ap_rst)
    if (ap_rst) stat_q <= '0;
    else
      for (int k = 0; k < NCH; k++)
        if (out_r_write[k]) stat_q[k] <= stat_q[k] + 32'd1;

  assign stat_words = stat_q;
`endif
endmodule

// File: tb/tb_ap_fifo_share_arbiter.sv
// Scoreboard bench: sources and an IP loopback model drive the arbiter; a monitor checks returns.
module tb_ap_fifo_share_arbiter;
  localparam int NCH = 4;
  localparam int DW  = 16;
  localparam int BL  = 4;
  localparam int TD  = 32;

  logic              ap_clk = 1'b0;
  logic              ap_rst;
  logic [NCH*DW-1:0] in_r_dout;
  logic [NCH-1:0]    in_r_empty_n;
  logic [NCH-1:0]    in_r_read;
  logic [NCH*DW-1:0] out_r_din;
  logic [NCH-1:0]    out_r_full;
  logic [NCH-1:0]    out_r_write;
  logic [DW-1:0]     ip_in_dout;
  logic              ip_in_empty_n;
  logic              ip_in_read;
  logic [DW-1:0]     ip_out_din;
  logic              ip_out_full_n;
  logic              ip_out_write;
  logic [1:0]        grant;
  logic              busy;
`ifdef ARB_STATS_EN
  logic [NCH*32-1:0] stat_words;
`endif

  ap_fifo_share_arbiter #(.NCH(NCH), .DW(DW), .BURST_LEN(BL), .TAG_DEPTH(TD)) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst),
    .in_r_dout(in_r_dout), .in_r_empty_n(in_r_empty_n), .in_r_read(in_r_read),
    .out_r_din(out_r_din), .out_r_full(out_r_full), .out_r_write(out_r_write),
    .ip_in_dout(ip_in_dout), .ip_in_empty_n(ip_in_empty_n), .ip_in_read(ip_in_read),
    .ip_out_din(ip_out_din), .ip_out_full_n(ip_out_full_n), .ip_out_write(ip_out_write),
    .grant(grant), .busy(busy)
`ifdef ARB_STATS_EN
    , .stat_words(stat_words)
`endif
  );

  always #5 ap_clk = ~ap_clk;

  logic [DW-1:0] src [NCH][$];
  logic [DW-1:0] expq[NCH][$];
  logic [DW-1:0] ipq[$];
  int            gseq[$];
  int            blen[$];
  int vectors = 0, errs = 0, nreads = 0, cur_len = 0, seqn = 0;
  bit busy_prev = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    vectors++;
    if (act !== expv) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, expv);
    end
  endtask

  // Stimulus side: each word goes to its source queue and, at the same moment, to the scoreboard.
  task automatic load(input int k, input int n);
    logic [DW-1:0] w;
    for (int i = 0; i < n; i++) begin
      w = {4'(k), 12'(seqn)};
      seqn++;
      src[k].push_back(w);
      expq[k].push_back(w);
    end
  endtask

  function automatic bit all_empty();
    bit e = (ipq.size() == 0);
    for (int k = 0; k < NCH; k++)
      if (src[k].size() != 0 || expq[k].size() != 0) e = 0;
    return e;
  endfunction

  task automatic wait_drain(input string nm, input int budget);
    bit done = 0;
    for (int c = 0; c < budget && !done; c++) begin
      @(posedge ap_clk);
      done = all_empty();
    end
    vectors++;
    if (!done) begin
      errs++;
      $display("FAIL %s_drain: got not-drained expected drained within %0d cycles", nm, budget);
    end
    repeat (3) @(posedge ap_clk);
    #1;
  endtask

  task automatic clear_all();
    for (int k = 0; k < NCH; k++) begin
      src[k].delete();
      expq[k].delete();
    end
    ipq.delete();
    gseq.delete();
    blen.delete();
  endtask

  task automatic check_rst(input string nm);
    chk({nm, "_in_r_read"},     64'(in_r_read),     64'd0);
    chk({nm, "_out_r_write"},   64'(out_r_write),   64'd0);
    chk({nm, "_ip_in_empty_n"}, 64'(ip_in_empty_n), 64'd0);
    chk({nm, "_ip_out_full_n"}, 64'(ip_out_full_n), 64'd0);
    chk({nm, "_grant"},         64'(grant),         64'd0);
    chk({nm, "_busy"},          64'(busy),          64'd0);
    chk({nm, "_ip_in_dout"},    64'(ip_in_dout),    64'(in_r_dout[DW-1:0]));
    chk({nm, "_out_r_din"},     64'(out_r_din),     64'({NCH{ip_out_din}}));
  endtask

  // Channel sources and IP loopback: drive at negedge, sample 2 units later.
  initial begin : drv
    forever begin
      @(negedge ap_clk);
      for (int k = 0; k < NCH; k++) begin
        in_r_empty_n[k]        = (src[k].size() > 0);
        in_r_dout[k*DW +: DW]  = (src[k].size() > 0) ? src[k][0] : '0;
      end
      ip_out_din = (ipq.size() > 0) ? ipq[0] : '0;
      #1;
      ip_out_write = (ipq.size() > 0) && ip_out_full_n;
      #1;
      if (ap_rst) begin
        cur_len   = 0;
        busy_prev = 0;
      end else begin
        if (ip_in_read && ip_in_empty_n) ipq.push_back(ip_in_dout);
        if (ip_out_write && ip_out_full_n) void'(ipq.pop_front());
        for (int k = 0; k < NCH; k++)
          if (in_r_read[k]) begin
            void'(src[k].pop_front());
            nreads++;
            cur_len++;
          end
        if (busy && !busy_prev) gseq.push_back(int'(grant));
        if (!busy && busy_prev) begin
          blen.push_back(cur_len);
          cur_len = 0;
        end
        busy_prev = busy;
      end
    end
  end

  // Monitor: every word the block writes to a sink is checked against that channel's scoreboard.
  initial begin : mon
    logic [DW-1:0] e;
    forever begin
      @(negedge ap_clk);
      #2;
      if (!ap_rst && out_r_write != '0) begin
        chk("out_write_onehot", 64'($onehot(out_r_write)), 64'd1);
        for (int k = 0; k < NCH; k++)
          if (out_r_write[k]) begin
            vectors++;
            if (expq[k].size() == 0) begin
              errs++;
              $display("FAIL out_extra_ch%0d: got word 0x%0h expected none", k, out_r_din[k*DW +: DW]);
            end else begin
              e = expq[k].pop_front();
              if (out_r_din[k*DW +: DW] !== e) begin
                errs++;
                $display("FAIL out_data_ch%0d: got 0x%0h expected 0x%0h", k, out_r_din[k*DW +: DW], e);
              end
            end
          end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs + 1);
    $fatal(1);
  end

  initial begin : stim
    int base;
    ap_rst       = 1'b1;
    ip_in_read   = 1'b1;
    out_r_full   = '0;
    ip_out_write = 1'b0;
    ip_out_din   = '0;
    in_r_dout    = '0;
    in_r_empty_n = '0;
    @(negedge ap_clk);
    #4;
    check_rst("rst0");
    @(negedge ap_clk);
    #3;
    ap_rst = 1'b0;
    @(posedge ap_clk);
    #1;

    // Single channel, 40 words: ten full bursts, all granted to channel 0.
    load(0, 40);
    wait_drain("t1", 400);
    chk("t1_nbursts", 64'(blen.size()), 64'd10);
    for (int i = 0; i < blen.size(); i++) chk($sformatf("t1_blen%0d", i), 64'(blen[i]), 64'd4);
    chk("t1_grant0", 64'(gseq.size() > 0 ? gseq[0] : -1), 64'd0);

    // All channels backlogged: rotation starts after channel 0.
    clear_all();
    for (int k = 0; k < NCH; k++) load(k, 8);
    wait_drain("t2", 400);
    chk("t2_nbursts", 64'(gseq.size()), 64'd8);
    for (int i = 0; i < gseq.size(); i++) begin
      chk($sformatf("t2_grant%0d", i), 64'(gseq[i]), 64'((i + 1) % NCH));
      chk($sformatf("t2_blen%0d", i), 64'(i < blen.size() ? blen[i] : -1), 64'd4);
    end

    // Blocked sink on channel 2: tags fill at 32, then release drains in order.
    clear_all();
    out_r_full = 4'b0100;
    load(2, 40);
    repeat (100) @(posedge ap_clk);
    #1;
    chk("t3_ip_out_full_n", 64'(ip_out_full_n), 64'd0);
    chk("t3_ip_in_empty_n", 64'(ip_in_empty_n), 64'd0);
    chk("t3_busy",          64'(busy),          64'd1);
    chk("t3_inflight",      64'(ipq.size()),    64'd32);
    chk("t3_src_left",      64'(src[2].size()), 64'd8);
    chk("t3_grant0",        64'(gseq.size() > 0 ? gseq[0] : -1), 64'd2);
    out_r_full = '0;
    wait_drain("t3", 400);

    // Channel 1 runs dry after 3 words; channel 2 is next.
    clear_all();
    load(1, 3);
    load(2, 2);
    wait_drain("t4", 200);
    chk("t4_nbursts", 64'(gseq.size()), 64'd2);
    chk("t4_grant0",  64'(gseq.size() > 0 ? gseq[0] : -1), 64'd1);
    chk("t4_grant1",  64'(gseq.size() > 1 ? gseq[1] : -1), 64'd2);
    chk("t4_blen0",   64'(blen.size() > 0 ? blen[0] : -1), 64'd3);
    chk("t4_blen1",   64'(blen.size() > 1 ? blen[1] : -1), 64'd2);

    // Reset with 5 words in flight.
    clear_all();
    out_r_full = 4'b0001;
    base = nreads;
    load(0, 10);
    for (int c = 0; c < 60 && (nreads - base) < 5; c++) begin
      @(negedge ap_clk);
      #3;
    end
    chk("t5_reads_before_rst", 64'(nreads - base), 64'd5);
    @(negedge ap_clk);
    #3;
    ap_rst = 1'b1;
    #1;
    check_rst("t5_rst");
    clear_all();
    out_r_full = '0;
    @(negedge ap_clk);
    #3;
    ap_rst = 1'b0;
    @(posedge ap_clk);
    #1;
    for (int k = NCH - 1; k >= 0; k--) load(k, 1);
    wait_drain("t5", 200);
    chk("t5_nbursts", 64'(gseq.size()), 64'd4);
    for (int i = 0; i < gseq.size(); i++) chk($sformatf("t5_grant%0d", i), 64'(gseq[i]), 64'(i));

`ifdef ARB_STATS_EN
    @(negedge ap_clk);
    #3;
    ap_rst = 1'b1;
    @(negedge ap_clk);
    #3;
    ap_rst = 1'b0;
    clear_all();
    @(posedge ap_clk);
    #1;
    load(3, 7);
    wait_drain("t6", 200);
    for (int k = 0; k < NCH; k++)
      chk($sformatf("t6_stat%0d", k), 64'(stat_words[k*32 +: 32]), (k == 3) ? 64'd7 : 64'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
